// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the E-stage multiply/divide unit.
// Provides the MDU op encoding, default MDU latencies, the datapath width
// and the result record produced by the MDU arithmetic.
package cpu_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned MUL_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF = 10;

  // Decoded MDU op carried in the ID/EX register. Values 9-15 behave as NONE.
  typedef enum logic [3:0] {
    MduNone  = 4'd0,
    MduMult  = 4'd1,
    MduMultu = 4'd2,
    MduDiv   = 4'd3,
    MduDivu  = 4'd4,
    MduMthi  = 4'd5,
    MduMtlo  = 4'd6,
    MduMfhi  = 4'd7,
    MduMflo  = 4'd8
  } mdu_op_e;

  // Result of a multi-cycle op; wr=0 means HI/LO stay untouched (divide by zero).
  typedef struct packed {
    logic            wr;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } mdu_res_t;

  function automatic logic mdu_is_start(logic [3:0] op);
    return (op == MduMult) || (op == MduMultu) || (op == MduDiv) || (op == MduDivu);
  endfunction

  function automatic logic mdu_is_div(logic [3:0] op);
    return (op == MduDiv) || (op == MduDivu);
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit.
// Owns the architectural HI/LO registers. mult/multu/div/divu compute their
// result in the issue cycle, hold it as pending and commit it to HI/LO after a
// fixed busy period; mthi/mtlo write directly, mfhi/mflo read HI/LO.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   req_i          - exception/interrupt flush of the E-stage instruction
//   mdu_op_i       - decoded MDU op (cpu_pkg encoding)
//   rs_val_i/rt_val_i - forwarded operands
//   start_o        - a multi-cycle op is accepted this cycle
//   busy_o         - start_o | in-flight op, used by the hazard unit to stall
//   hilo_out_o     - LO for mflo, HI otherwise
module e_mdu
  import cpu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_i,
  input  logic [3:0]      mdu_op_i,
  input  logic [XLEN-1:0] rs_val_i,
  input  logic [XLEN-1:0] rt_val_i,
  output logic            start_o,
  output logic            busy_o,
  output logic [XLEN-1:0] hilo_out_o
);

  localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  mdu_res_t        pend_q, pend_d;

  // Full arithmetic for the four multi-cycle ops, evaluated in the issue cycle.
  function automatic mdu_res_t mdu_compute(logic [3:0] op, logic [XLEN-1:0] a,
                                           logic [XLEN-1:0] b);
    mdu_res_t        res;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0] ma, mb, q, r;
    res  = '0;
    prod = '0;
    ma   = '0;
    mb   = '0;
    q    = '0;
    r    = '0;
    case (op)
      MduMult: begin
        // Low 2*XLEN bits of a product of sign-extended operands equal the signed product.
        prod   = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
        res.wr = 1'b1;
        res.hi = prod[2*XLEN-1:XLEN];
        res.lo = prod[XLEN-1:0];
      end
      MduMultu: begin
        prod   = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
        res.wr = 1'b1;
        res.hi = prod[2*XLEN-1:XLEN];
        res.lo = prod[XLEN-1:0];
      end
      MduDiv: begin
        if (b != '0) begin
          // Divide magnitudes then re-apply signs; -MIN wraps to MIN, which is
          // the correct unsigned magnitude, so MIN / -1 yields MIN with rem 0.
          ma     = a[XLEN-1] ? -a : a;
          mb     = b[XLEN-1] ? -b : b;
          q      = ma / mb;
          r      = ma % mb;
          res.wr = 1'b1;
          res.lo = (a[XLEN-1] ^ b[XLEN-1]) ? -q : q;
          res.hi = a[XLEN-1] ? -r : r;
        end
      end
      MduDivu: begin
        if (b != '0) begin
          res.wr = 1'b1;
          res.lo = a / b;
          res.hi = a % b;
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  always_comb begin
    start_o    = mdu_is_start(mdu_op_i) && !busy_q && !req_i;
    busy_o     = start_o || busy_q;
    hilo_out_o = (mdu_op_i == MduMflo) ? lo_q : hi_q;
  end

  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    busy_d = busy_q;
    cnt_d  = cnt_q;
    pend_d = pend_q;
    if (busy_q) begin
      // In-flight op runs to completion even if req_i flushes a later instruction.
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        if (pend_q.wr) begin
          hi_d = pend_q.hi;
          lo_d = pend_q.lo;
        end
      end
    end else if (!req_i) begin
      if (start_o) begin
        pend_d = mdu_compute(mdu_op_i, rs_val_i, rt_val_i);
        cnt_d  = mdu_is_div(mdu_op_i) ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
        busy_d = 1'b1;
      end else if (mdu_op_i == MduMthi) begin
        hi_d = rs_val_i;
      end else if (mdu_op_i == MduMtlo) begin
        lo_d = rs_val_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      cnt_q  <= '0;
      pend_q <= '0;
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Bench for e_mdu: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural HI/LO model.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_i;
  logic [3:0]  mdu_op_i;
  logic [31:0] rs_val_i;
  logic [31:0] rt_val_i;
  logic        start_o;
  logic        busy_o;
  logic [31:0] hilo_out_o;

  e_mdu #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_i      (req_i),
    .mdu_op_i   (mdu_op_i),
    .rs_val_i   (rs_val_i),
    .rt_val_i   (rt_val_i),
    .start_o    (start_o),
    .busy_o     (busy_o),
    .hilo_out_o (hilo_out_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: architectural HI/LO plus an outstanding op with its commit cycle.
  logic [31:0] m_hi, m_lo;
  logic        m_active;
  int          m_commit_at;
  logic        m_pend_ok;
  logic [31:0] m_pend_hi, m_pend_lo;
  int          cyc = 0;

  logic        exp_start, exp_busy;
  logic [31:0] exp_hilo;
  logic        chk_en = 1'b0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic is_start(logic [3:0] op);
    return op >= 4'd1 && op <= 4'd4;
  endfunction

  // Reference arithmetic from plain 64-bit integer operations.
  function automatic void model_exec(input logic [3:0] op, input logic [31:0] a,
                                     input logic [31:0] b, output logic ok,
                                     output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, sp, sq, sr;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    ok = 1'b1;
    h  = '0;
    l  = '0;
    case (op)
      4'd1: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; end
      4'd2: begin up = ua * ub; h = up[63:32]; l = up[31:0]; end
      4'd3: begin
        if (b == 0) ok = 1'b0;
        else begin sq = sa / sb; sr = sa % sb; h = sr[31:0]; l = sq[31:0]; end
      end
      default: begin
        if (b == 0) ok = 1'b0;
        else begin up = ua / ub; h = up[31:0]; up = ua % ub; h = up[31:0];
          up = ua / ub; l = up[31:0]; up = ua % ub; h = up[31:0]; end
      end
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic rq, input logic rst);
    mdu_op_i  = op;
    rs_val_i  = rs;
    rt_val_i  = rt;
    req_i     = rq;
    reset     = rst;
    exp_start = is_start(op) && !m_active && !rq;
    exp_busy  = exp_start || m_active;
    exp_hilo  = (op == 4'd8) ? m_lo : m_hi;
    #1;
  endtask

  task automatic advance();
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_active = 1'b0;
    end else if (m_active) begin
      if (cyc == m_commit_at) begin
        if (m_pend_ok) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        m_active = 1'b0;
      end
    end else if (!req_i) begin
      if (is_start(mdu_op_i)) begin
        model_exec(mdu_op_i, rs_val_i, rt_val_i, m_pend_ok, m_pend_hi, m_pend_lo);
        m_active    = 1'b1;
        m_commit_at = cyc + ((mdu_op_i >= 4'd3) ? 10 : 5);
      end else if (mdu_op_i == 4'd5) m_hi = rs_val_i;
      else if (mdu_op_i == 4'd6) m_lo = rs_val_i;
    end
    #1;
  endtask

  // Count cycles with busy_o high, bounded so a stuck busy cannot hang the run.
  task automatic run_busy(input string nm, input int exp_n);
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy_o !== 1'b1) break;
      n++;
      advance();
      drive(4'd0, '0, '0, 1'b0, 1'b0);
    end
    chk(nm, n, exp_n);
  endtask

  task automatic read_lit(input string nm, input logic [3:0] op, input logic rq,
                          input logic [31:0] exp);
    drive(op, '0, '0, rq, 1'b0);
    chk(nm, hilo_out_o, exp);
    chk({nm, "_model"}, (op == 4'd8) ? m_lo : m_hi, exp);
    advance();
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("start_o", {31'd0, start_o}, {31'd0, exp_start});
      chk("busy_o", {31'd0, busy_o}, {31'd0, exp_busy});
      chk("hilo_out_o", hilo_out_o, exp_hilo);
    end
  end

  initial begin
    logic [31:0] a, b;
    logic [3:0]  op;
    m_hi = '0; m_lo = '0; m_active = 1'b0; m_commit_at = 0;
    m_pend_ok = 1'b0; m_pend_hi = '0; m_pend_lo = '0;
    drive(4'd0, '0, '0, 1'b0, 1'b1);
    advance();
    chk_en = 1'b1;
    drive(4'd0, '0, '0, 1'b0, 1'b1);
    advance();
    read_lit("reset_hi", 4'd7, 1'b0, 32'h0);
    read_lit("reset_lo", 4'd8, 1'b0, 32'h0);

    // MULT -1 * 2
    drive(4'd1, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0);
    chk("mult_start", {31'd0, start_o}, 32'd1);
    run_busy("mult_busy_len", 6);
    read_lit("mult_hi", 4'd7, 1'b0, 32'hFFFFFFFF);
    read_lit("mult_lo", 4'd8, 1'b0, 32'hFFFFFFFE);

    drive(4'd2, 32'hFFFFFFFF, 32'h2, 1'b0, 1'b0);
    run_busy("multu_busy_len", 6);
    read_lit("multu_hi", 4'd7, 1'b0, 32'h1);
    read_lit("multu_lo", 4'd8, 1'b0, 32'hFFFFFFFE);

    drive(4'd3, 32'd7, 32'hFFFFFFFE, 1'b0, 1'b0);
    run_busy("div_busy_len", 11);
    read_lit("div_hi", 4'd7, 1'b0, 32'h1);
    read_lit("div_lo", 4'd8, 1'b0, 32'hFFFFFFFD);

    drive(4'd4, 32'd7, 32'd2, 1'b0, 1'b0);
    run_busy("divu_busy_len", 11);
    read_lit("divu_hi", 4'd7, 1'b0, 32'h1);
    read_lit("divu_lo", 4'd8, 1'b0, 32'h3);

    drive(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_busy("divmin_busy_len", 11);
    read_lit("divmin_hi", 4'd7, 1'b0, 32'h0);
    read_lit("divmin_lo", 4'd8, 1'b0, 32'h80000000);

    drive(4'd5, 32'h12345678, '0, 1'b0, 1'b0);
    advance();
    drive(4'd6, 32'h9ABCDEF0, '0, 1'b0, 1'b0);
    advance();
    drive(4'd4, 32'd5, 32'd0, 1'b0, 1'b0);
    run_busy("div0_busy_len", 11);
    read_lit("div0_hi", 4'd7, 1'b0, 32'h12345678);
    read_lit("div0_lo", 4'd8, 1'b0, 32'h9ABCDEF0);

    // Flushed instructions have no effect; reads still work under req.
    drive(4'd1, 32'd3, 32'd4, 1'b1, 1'b0);
    chk("req_mult_start", {31'd0, start_o}, 32'd0);
    chk("req_mult_busy", {31'd0, busy_o}, 32'd0);
    advance();
    drive(4'd6, 32'hAAAA5555, '0, 1'b1, 1'b0);
    advance();
    read_lit("req_mflo", 4'd8, 1'b1, 32'h9ABCDEF0);
    read_lit("req_mfhi", 4'd7, 1'b0, 32'h12345678);

    // Reset four cycles into a divide aborts it.
    drive(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(4'd0, '0, '0, 1'b0, 1'b0);
      advance();
    end
    drive(4'd0, '0, '0, 1'b0, 1'b1);
    advance();
    drive(4'd0, '0, '0, 1'b0, 1'b0);
    chk("abort_busy", {31'd0, busy_o}, 32'd0);
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(4'd0, '0, '0, 1'b0, 1'b0);
      advance();
    end
    read_lit("abort_hi", 4'd7, 1'b0, 32'h0);
    read_lit("abort_lo", 4'd8, 1'b0, 32'h0);

    // Random traffic; outputs checked every cycle by the negedge process.
    for (int i = 0; i < 3000; i++) begin
      op = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 5))
        0: a = 32'h80000000;
        1: a = 32'hFFFFFFFF;
        2: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'hFFFFFFFF;
        2: b = 32'($urandom_range(1, 9));
        default: b = $urandom;
      endcase
      drive(op, a, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 299) == 0));
      advance();
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
